// File: rtl/isa_pkg.sv
// isa_pkg: instruction field positions, opcode/ALUop constants and stall FSM types.
package isa_pkg;
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RD_HI = 26;
    localparam int RD_LO = 22;
    localparam int RS_HI = 21;
    localparam int RS_LO = 17;
    localparam int RT_HI = 16;
    localparam int RT_LO = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {IDLE, MD_ISSUE, MD_WAIT, MD_DONE} state_t;

    typedef struct packed {
        logic [4:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       is_lw;
        logic       is_md;
        logic       is_mul;
        logic       uses_rs;
        logic       uses_rt;
        logic       uses_rd;
    } fields_t;
endpackage

// File: rtl/instr_fields.sv
// instr_fields: pure decode of one instruction word into register fields and hazard-relevant flags.
module instr_fields
    import isa_pkg::*;
(
    input  logic [31:0] ir,
    output fields_t     f
);
    logic [4:0] op;
    logic [4:0] alu;
    logic       rtype;
    logic       br;
    logic       unused_bits;

    assign op     = ir[OP_HI:OP_LO];
    assign alu    = ir[ALU_HI:ALU_LO];
    assign rtype  = op == OP_RTYPE;
    assign br     = op == OP_BNE || op == OP_BLT;

    assign f.opcode  = op;
    assign f.rd      = ir[RD_HI:RD_LO];
    assign f.rs      = ir[RS_HI:RS_LO];
    assign f.rt      = ir[RT_HI:RT_LO];
    assign f.is_lw   = op == OP_LW;
    assign f.is_mul  = rtype && alu == ALU_MUL;
    assign f.is_md   = rtype && (alu == ALU_MUL || alu == ALU_DIV);
    assign f.uses_rs = rtype || br || op == OP_ADDI || op == OP_SW || op == OP_LW;
    assign f.uses_rt = rtype;
    // sw Rd is store data and is bypassed X->M, so it never counts as a read here
    assign f.uses_rd = br || op == OP_JR;

    assign unused_bits = ^{ir[ALU_LO-1:0], ir[RT_LO-1:ALU_HI+1]};
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use, mult/div and branch-redirect stall/flush control for the 5-stage core.
// Define STALL_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_stall_ctrl
    import isa_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_X,
    input  logic        branch_taken,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        en_F,
    output logic        en_D,
    output logic        en_X,
    output logic        nop_X,
    output logic        nop_M,
    output logic        flush_D,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic        md_busy,
    output logic        md_error
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] md_stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    fields_t          df;
    fields_t          xf;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             md_div;
    logic             idle;
    logic             load_use;
    logic             stall_lu;
    logic             flush;
    logic             timeout;
    logic             unused_bits;

    instr_fields u_dec_d (.ir(IR_D), .f(df));
    instr_fields u_dec_x (.ir(IR_X), .f(xf));

    assign load_use = xf.is_lw && xf.rd != '0 &&
                      ((df.uses_rs && df.rs == xf.rd) ||
                       (df.uses_rt && df.rt == xf.rd) ||
                       (df.uses_rd && df.rd == xf.rd));

    assign idle     = state == IDLE;
    assign flush    = idle && branch_taken;
    assign stall_lu = idle && !branch_taken && load_use;
    assign md_busy  = state == MD_ISSUE || state == MD_WAIT;
    assign timeout  = state == MD_WAIT && cnt == CNT_W'(MD_TIMEOUT - 1);

    assign en_F          = !(stall_lu || md_busy);
    assign en_D          = !(stall_lu || md_busy);
    assign en_X          = !md_busy;
    assign nop_X         = stall_lu || flush;
    assign nop_M         = md_busy;
    assign flush_D       = flush;
    assign md_start_mult = state == MD_ISSUE && !md_div;
    assign md_start_div  = state == MD_ISSUE && md_div;
    assign md_error      = timeout && !md_ready;

    // md_div latches the op kind at issue so the start pulse does not depend on IR_X afterwards
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            md_div <= 1'b0;
        end else begin
            state  <= idle ? (xf.is_md ? MD_ISSUE : IDLE)
                    : state == MD_DONE ? IDLE
                    : (md_ready || timeout) ? MD_DONE : MD_WAIT;
            cnt    <= state == MD_WAIT ? cnt + CNT_W'(1) : '0;
            md_div <= idle ? xf.is_md && !xf.is_mul : md_div;
        end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            load_stall_cnt <= '0;
            md_stall_cnt   <= '0;
            flush_cnt      <= '0;
        end else begin
            load_stall_cnt <= load_stall_cnt + {31'd0, stall_lu && !(&load_stall_cnt)};
            md_stall_cnt   <= md_stall_cnt + {31'd0, md_busy && !(&md_stall_cnt)};
            flush_cnt      <= flush_cnt + {31'd0, flush && !(&flush_cnt)};
        end
`endif

    assign unused_bits = ^{md_exception, df.opcode, df.is_lw, df.is_md, df.is_mul,
                           xf.opcode, xf.rs, xf.rt, xf.uses_rs, xf.uses_rt, xf.uses_rd};
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table vectors, randomized IDLE checks against a read-set model, and mult/div sequences.
module tb_hazard_stall_ctrl;
    localparam logic [9:0] E_DEF = 10'b1110000000;
    localparam logic [9:0] E_LU  = 10'b0011000000;
    localparam logic [9:0] E_FL  = 10'b1111010000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] IR_D = '0;
    logic [31:0] IR_X = '0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic        en_F, en_D, en_X, nop_X, nop_M, flush_D;
    logic        md_start_mult, md_start_div, md_busy, md_error;
    logic [9:0]  outv;
    int          nvec = 0;
    int          nerr = 0;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] load_stall_cnt, md_stall_cnt, flush_cnt;
`endif

    hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .IR_D(IR_D), .IR_X(IR_X),
        .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
        .en_F(en_F), .en_D(en_D), .en_X(en_X), .nop_X(nop_X), .nop_M(nop_M),
        .flush_D(flush_D), .md_start_mult(md_start_mult), .md_start_div(md_start_div),
        .md_busy(md_busy), .md_error(md_error)
`ifdef STALL_PERF_CNT_EN
        , .load_stall_cnt(load_stall_cnt), .md_stall_cnt(md_stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    assign outv = {en_F, en_D, en_X, nop_X, nop_M, flush_D, md_start_mult, md_start_div, md_busy, md_error};

    function automatic logic [31:0] r_ins(int rd, int rs, int rt, int alu);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rd, int rs);
        return {5'(op), 5'(rd), 5'(rs), 17'd0};
    endfunction

    // Reference: collect the registers the D instruction reads, then ask whether the lw in X writes one
    function automatic logic [9:0] ref_idle(logic [31:0] d, logic [31:0] x, logic br);
        int reads[$];
        int dop = int'(d[31:27]);
        bit hz = 0;
        if (dop == 0) reads = '{int'(d[21:17]), int'(d[16:12])};
        else if (dop == 5 || dop == 7 || dop == 8) reads = '{int'(d[21:17])};
        else if (dop == 2 || dop == 6) reads = '{int'(d[21:17]), int'(d[26:22])};
        else if (dop == 4) reads = '{int'(d[26:22])};
        if (x[31:27] == 5'd8 && x[26:22] != 5'd0)
            foreach (reads[i]) if (reads[i] == int'(x[26:22])) hz = 1;
        return br ? E_FL : hz ? E_LU : E_DEF;
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        nvec++;
        if (outv !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (enF enD enX nopX nopM flushD smul sdiv busy err)", name, outv, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #3;
    endtask

    // k: cycle after the edge into MD_ISSUE at which md_ready pulses (0 = during ISSUE, <0 = never)
    task automatic run_md(input bit div, input int k);
        bit to = (k < 0 || k > 40);
        int b = to ? 41 : (k == 0 ? 1 : k + 1);
        IR_X = r_ins(7, 1, 2, div ? 7 : 6);
        IR_D = r_ins(4, 1, 2, 0);
        md_ready = 0;
        branch_taken = 0;
        #1 check("md_idle_before", E_DEF);
        for (int c = 0; c <= b + 1; c++) begin
            step();
            md_ready = (k >= 0 && c == k && c < b);
            branch_taken = (c < b);
            if (c == b) IR_X = '0;
            #1;
            if (c < b)
                check($sformatf("md_busy_c%0d_k%0d", c, k),
                      {6'b000010, c == 0 && !div, c == 0 && div, 1'b1, to && c == b - 1});
            else
                check($sformatf("md_after_c%0d_k%0d", c, k), E_DEF);
        end
        md_ready = 0;
        branch_taken = 0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] x;
        logic        br;
        logic [9:0]  e;
    } vec_t;

    vec_t tbl[15];
    int   ops[9] = '{0, 5, 7, 8, 2, 6, 4, 1, 3};

    initial begin
        tbl[0]  = '{"lu_rs_add",     r_ins(5, 3, 4, 0), i_ins(8, 3, 1), 0, E_LU};
        tbl[1]  = '{"lw_r0_nostall", r_ins(5, 0, 4, 0), i_ins(8, 0, 1), 0, E_DEF};
        tbl[2]  = '{"lu_rt_add",     r_ins(5, 4, 3, 0), i_ins(8, 3, 1), 0, E_LU};
        tbl[3]  = '{"lu_addi_rs",    i_ins(5, 5, 3),    i_ins(8, 3, 1), 0, E_LU};
        tbl[4]  = '{"sw_rd_only",    i_ins(7, 3, 4),    i_ins(8, 3, 1), 0, E_DEF};
        tbl[5]  = '{"sw_rs_base",    i_ins(7, 4, 3),    i_ins(8, 3, 1), 0, E_LU};
        tbl[6]  = '{"bne_rd",        i_ins(2, 3, 4),    i_ins(8, 3, 1), 0, E_LU};
        tbl[7]  = '{"blt_rs",        i_ins(6, 4, 3),    i_ins(8, 3, 1), 0, E_LU};
        tbl[8]  = '{"jr_rd",         i_ins(4, 3, 0),    i_ins(8, 3, 1), 0, E_LU};
        tbl[9]  = '{"branch_over_lu",r_ins(5, 3, 4, 0), i_ins(8, 3, 1), 1, E_FL};
        tbl[10] = '{"add_in_x_fwd",  r_ins(5, 3, 4, 0), r_ins(3, 1, 2, 0), 0, E_DEF};
        tbl[11] = '{"lw_lw_other",   i_ins(8, 5, 4),    i_ins(8, 3, 1), 0, E_DEF};
        tbl[12] = '{"lw_lw_base",    i_ins(8, 5, 3),    i_ins(8, 3, 1), 0, E_LU};
        tbl[13] = '{"branch_alone",  32'd0,             32'd0,          1, E_FL};
        tbl[14] = '{"rtype_rd_only", r_ins(3, 4, 5, 0), i_ins(8, 3, 1), 0, E_DEF};

        #3 check("reset_outputs", E_DEF);
        step();
        reset_n = 1;
        #1 check("idle_after_reset", E_DEF);

        foreach (tbl[i]) begin
            step();
            IR_D = tbl[i].d;
            IR_X = tbl[i].x;
            branch_taken = tbl[i].br;
            #1 check(tbl[i].name, tbl[i].e);
        end

        // load-use lasts one cycle: the lw advances and the hazard clears
        step();
        IR_D = r_ins(5, 3, 4, 0); IR_X = i_ins(8, 3, 1); branch_taken = 0;
        #1 check("lu_seq_stall", E_LU);
        step();
        IR_D = r_ins(6, 1, 1, 0); IR_X = r_ins(5, 3, 4, 0);
        #1 check("lu_seq_release", E_DEF);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] d, x;
            logic        br;
            int          xop;
            step();
            d = {5'(ops[$urandom_range(8)]), 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom), 5'($urandom_range(7)), 2'($urandom)};
            xop = ops[$urandom_range(8)];
            if ($urandom_range(1)) xop = 8;
            x = {5'(xop), 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom), 5'($urandom_range(5)), 2'($urandom)};
            br = ($urandom_range(3) == 0);
            IR_D = d; IR_X = x; branch_taken = br;
            #1 check($sformatf("rand_%0d", n), ref_idle(d, x, br));
        end

        step();
        IR_D = '0; IR_X = '0; branch_taken = 0;
        #1 check("idle_before_md", E_DEF);

        // reset mid-wait, then a fresh mul must issue
        IR_X = r_ins(7, 1, 2, 6);
        step();
        #1 check("abort_issue", 10'b0000101010);
        repeat (3) step();
        #1 check("abort_wait", 10'b0000100010);
        reset_n = 0;
        #1 check("abort_reset_now", E_DEF);
        reset_n = 1;

        run_md(0, 5);
        run_md(1, -1);
        run_md(1, 0);
        run_md(0, 1);
        run_md(1, 40);
        run_md(0, 41);
        for (int n = 0; n < 3; n++) run_md(1'($urandom), int'($urandom_range(45)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. It sits beside the X/M/W forwarding unit and covers the hazards forwarding cannot resolve: load-use, multi-cycle mult/div, and taken-branch/jump redirects.
- It generates pipeline-register enables, bubble (nop) injections and mult/div start pulses, so the F/D/X/M latches never capture an unresolved operand.

Parameters:
- MD_TIMEOUT, 40, cycles to wait for md_ready before aborting the mult/div with md_error.
- CNT_W, 6, width of the mult/div wait counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IR_D  in  32  instruction in the Decode stage.
- IR_X  in  32  instruction in the Execute stage.
- branch_taken  in  1  X-stage branch/jump resolved as redirecting (bne/blt taken, j, jal, jr, bex taken).
- md_ready  in  1  mult/div unit result valid; single-cycle pulse.
- md_exception  in  1  mult/div overflow/div0, qualified by md_ready.
- en_F  out  1  PC/F latch enable.
- en_D  out  1  F/D latch enable.
- en_X  out  1  D/X latch enable.
- nop_X  out  1  load a nop into D/X instead of the D instruction.
- nop_M  out  1  load a nop into X/M instead of the X result.
- flush_D  out  1  load a nop into F/D.
- md_start_mult  out  1  one-cycle start pulse, multiply.
- md_start_div  out  1  one-cycle start pulse, divide.
- md_busy  out  1  high while a mult/div is in flight.
- md_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Decode fields:
  - opcode [31:27], Rd [26:22], Rs [21:17], Rt [16:12], ALUop [6:2].
  - R-type: opcode 00000. mul: ALUop 00110. div: ALUop 00111.
  - lw: 01000. sw: 00111. bne: 00010. blt: 00110. jr: 00100.
- Load-use hazard (combinational): IR_X is lw, X.Rd != 0, and any one of:
  - D.Rs == X.Rd for R-type, I-type, bne or blt;
  - D.Rt == X.Rd for R-type;
  - D.Rd == X.Rd for bne, blt or jr.
  - sw Rd is excluded; the X->M store-data bypass covers it.
- FSM states: IDLE, MD_ISSUE, MD_WAIT, MD_DONE. Reset state is IDLE.
- IDLE:
  - If IR_X is mul/div: go to MD_ISSUE.
  - Else, on load-use: en_F = en_D = 0, nop_X = 1 for exactly 1 cycle. No state change is needed, because the lw advances and clears the hazard.
- MD_ISSUE (1 cycle):
  - Pulse md_start_mult or md_start_div. Load the counter with 0.
  - en_F = en_D = en_X = 0, nop_M = 1, md_busy = 1.
  - Go to MD_WAIT.
- MD_WAIT:
  - Same enables as MD_ISSUE. Counter increments each cycle.
  - md_ready = 1: go to MD_DONE.
  - Counter == MD_TIMEOUT-1 with no md_ready: pulse md_error, go to MD_DONE.
- MD_DONE (1 cycle):
  - All enables 1, nop_M = 0, md_busy = 0. X/M captures the result. Go to IDLE.
  - The mult/div in X is not re-issued, because IR_X changes on this edge.
- Taken branch (IDLE only): flush_D = 1 and nop_X = 1 in the same cycle, enables = 1. It has priority over load-use.
  - A branch cannot coexist with a mul/div in X, so the MD states ignore branch_taken.
- md_ready arriving in MD_ISSUE is treated as arriving in MD_WAIT: next state is MD_DONE.
- Reset mid-operation: immediate return to IDLE, counter 0.
- Output values in reset/IDLE with no hazard: en_F = en_D = en_X = 1; every other output 0.
- All outputs are combinational from state plus IR_D/IR_X/branch_taken. Zero added latency.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs load_stall_cnt, md_stall_cnt and flush_cnt.
  - They count cycles with a load-use bubble, cycles in MD_ISSUE/MD_WAIT, and taken-branch flushes.
  - All three are asynchronously cleared by reset_n and saturate at all-ones.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Package isa_pkg: opcode constants, ALUop constants, field bit ranges, fsm state typedef (2-bit enum).
- Sub-module instr_fields: pure decode returning opcode, Rd/Rs/Rt, is_lw, is_md, is_mul, uses_rs/rt/rd. Instantiated twice, for D and X.

Test Plan:
- lw r3 in X, add r5,r3,r4 in D -> en_F = en_D = 0, nop_X = 1 for 1 cycle, then all enables 1. Same with lw r0 -> no stall.
- mul in X, md_ready at the 5th cycle after MD_ISSUE -> md_start_mult pulse in cycle 1, md_busy high until MD_DONE, nop_M high 6 cycles, then en_* = 1 for one MD_DONE cycle.
- div with md_ready never asserted, MD_TIMEOUT = 40 -> md_error pulses on wait cycle 40, FSM returns to IDLE via MD_DONE.
- branch_taken = 1 with a load-use also present -> flush_D = 1, nop_X = 1, en_F = 1; no load stall.
- reset_n dropped during MD_WAIT -> outputs go to reset values immediately; after release, a new mul in X issues a fresh md_start_mult.
- sw r3 in D with lw r3 in X (Rd match only) -> no stall.
